// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    // Key index 0..3 = A, S, D, F
    localparam logic [31:0] PS2_DEFAULT_KEYMAP = {8'h2B, 8'h23, 8'h1B, 8'h1C};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } frame_state_t;

    // Odd parity across data and parity bit must come out as 1
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and filters the bus, shifts in 11-bit
// frames on filtered clock falling edges, validates them and aborts stalls.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2clock,
    input  logic       i_ps2data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_error
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    logic                      r_clk_s1, r_clk_s2;
    logic                      r_dat_s1, r_dat_s2;
    logic                      r_clk_filt, r_clk_filt_d;
    logic [FW-1:0]             r_filt_cnt;
    logic [PS2_FRAME_BITS-1:0] r_shift;
    logic [3:0]                r_bit_cnt;
    logic [WW-1:0]             r_wd;
    frame_state_t              r_state, w_next;

    logic w_fall;
    logic w_timeout;
    logic w_frame_ok;

    assign w_fall     = r_clk_filt_d & ~r_clk_filt;
    assign w_timeout  = (r_state == ST_SHIFT) && (r_wd == WW'(TIMEOUT_CYCLES));
    assign w_frame_ok = ~r_shift[0] & r_shift[10] & ps2_parity_ok(r_shift[8:1], r_shift[9]);
    assign o_byte     = r_shift[8:1];

    // Two-flop synchronisers, bus idles high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2clock;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Glitch filter: level follows only after FILTER_LEN consecutive differing samples
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Frame FSM next state and strobes
    always_comb begin
        w_next        = r_state;
        o_byte_valid  = 1'b0;
        o_frame_error = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_timeout) begin
                    w_next        = ST_IDLE;
                    o_frame_error = 1'b1;
                end else if (w_fall && r_bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_next        = ST_IDLE;
                o_byte_valid  = w_frame_ok;
                o_frame_error = ~w_frame_ok;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Shifter (LSB first into the top, start bit ends at bit 0), bit counter, watchdog
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_wd      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wd <= '0;
                    if (w_fall) begin
                        r_shift   <= {r_dat_s2, {(PS2_FRAME_BITS-1){1'b0}}};
                        r_bit_cnt <= 4'd1;
                    end
                end
                ST_SHIFT: begin
                    if (w_timeout) begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                        r_wd      <= '0;
                    end else if (w_fall) begin
                        r_shift   <= {r_dat_s2, r_shift[PS2_FRAME_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_wd      <= '0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                    r_wd      <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: parses make/break/extended sequences, maps scancodes to
// key indices and emits one event per key state change plus a held-key bitmap.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned             NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]   KEYMAP         = PS2_DEFAULT_KEYMAP,
    parameter int unsigned             FILTER_LEN     = 8,
    parameter int unsigned             TIMEOUT_CYCLES = 100000
) (
    input  logic                                            CLOCK_50,
    input  logic                                            reset,
    input  logic                                            ps2clock,
    input  logic                                            ps2data,
    output logic                                            key_valid,
    output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] key_index,
    output logic                                            key_make,
    output logic [NUM_KEYS-1:0]                             key_down,
    output logic                                            frame_error
);

    localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic             w_byte_valid;
    logic [7:0]       w_byte;
    logic             w_frame_error;
    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    logic             r_brk;
    logic             r_ext;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk         (CLOCK_50),
        .i_rst         (reset),
        .i_ps2clock    (ps2clock),
        .i_ps2data     (ps2data),
        .o_byte_valid  (w_byte_valid),
        .o_byte        (w_byte),
        .o_frame_error (w_frame_error)
    );

    // Keymap lookup; scanning downward so the lowest matching index wins
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int unsigned i = NUM_KEYS; i > 0; i--) begin
            if (KEYMAP[8*(i-1) +: 8] == w_byte) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i - 1);
            end
        end
    end

    // Prefix flags, event register and held-key bitmap
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_valid   <= 1'b0;
            key_index   <= '0;
            key_make    <= 1'b0;
            key_down    <= '0;
            frame_error <= 1'b0;
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            frame_error <= w_frame_error;
            if (w_frame_error) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte == PS2_BREAK) begin
                    r_brk <= 1'b1;
                end else if (w_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else begin
                    if (!r_ext && w_hit && (key_down[w_idx] == r_brk)) begin
                        key_valid       <= 1'b1;
                        key_index       <= w_idx;
                        key_make        <= ~r_brk;
                        key_down[w_idx] <= ~r_brk;
                    end
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames and checks events.
module tb_ps2_key_decoder;

    localparam int unsigned TMO = 2000;
    // Stop-bit clock low -> key_valid: 2 sync flops + 8 filter samples + edge cycle + CHECK + event register
    localparam int LATENCY = 12;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2clock = 1'b1;
    logic       ps2data  = 1'b1;
    logic       key_valid;
    logic [1:0] key_index;
    logic       key_make;
    logic [3:0] key_down;
    logic       frame_error;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int ev_cnt  = 0;
    int err_cnt = 0;
    int ev_idx  = -1;
    int ev_make = -1;
    int ev_cyc  = 0;
    int t_stop  = 0;

    ps2_key_decoder #(
        .NUM_KEYS       (4),
        .KEYMAP         (32'h2B231B1C),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .ps2clock    (ps2clock),
        .ps2data     (ps2data),
        .key_valid   (key_valid),
        .key_index   (key_index),
        .key_make    (key_make),
        .key_down    (key_down),
        .frame_error (frame_error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (key_valid) begin
                ev_cnt  = ev_cnt + 1;
                ev_idx  = int'(key_index);
                ev_make = int'(key_make);
                ev_cyc  = cyc;
            end
            if (frame_error) err_cnt = err_cnt + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Send up to nbits of a frame; optional parity flip and 3-cycle clock glitches
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            ps2data = f[k];
            wait_cyc(10);
            ps2clock = 1'b0;
            if (k == 10) t_stop = cyc;
            wait_cyc(20);
            ps2clock = 1'b1;
            if (glitch) begin
                wait_cyc(12);
                ps2clock = 1'b0;
                wait_cyc(3);
                ps2clock = 1'b1;
                wait_cyc(10);
            end else begin
                wait_cyc(10);
            end
        end
        ps2data = 1'b1;
        wait_cyc(40);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0);
    endtask

    int ev0, er0;

    initial begin
        wait_cyc(5);
        check("rst_valid", int'(key_valid), 0);
        check("rst_ferr",  int'(frame_error), 0);
        check("rst_down",  int'(key_down), 0);
        check("rst_index", int'(key_index), 0);
        check("rst_make",  int'(key_make), 0);
        reset = 1'b0;
        wait_cyc(5);

        // Press A with latency check
        ev0 = ev_cnt; er0 = err_cnt;
        send_byte(8'h1C);
        check("pressA_ev",   ev_cnt - ev0, 1);
        check("pressA_idx",  ev_idx, 0);
        check("pressA_make", ev_make, 1);
        check("pressA_down", int'(key_down), 4'b0001);
        check("pressA_lat",  ev_cyc - t_stop, LATENCY);
        check("pressA_err",  err_cnt - er0, 0);

        // Release A
        ev0 = ev_cnt;
        send_byte(8'hF0);
        check("brk_prefix_ev", ev_cnt - ev0, 0);
        send_byte(8'h1C);
        check("relA_ev",   ev_cnt - ev0, 1);
        check("relA_make", ev_make, 0);
        check("relA_down", int'(key_down), 4'b0000);

        // Typematic: three makes -> one event
        ev0 = ev_cnt;
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        check("typematic_ev",   ev_cnt - ev0, 1);
        check("typematic_down", int'(key_down), 4'b0001);
        send_byte(8'h1B);
        check("pressS_ev",   ev_cnt - ev0, 2);
        check("pressS_idx",  ev_idx, 1);
        check("pressS_down", int'(key_down), 4'b0011);

        // Bad parity
        ev0 = ev_cnt; er0 = err_cnt;
        send_frame(8'h23, 1'b1, 11, 1'b0);
        check("parity_err",  err_cnt - er0, 1);
        check("parity_ev",   ev_cnt - ev0, 0);
        check("parity_down", int'(key_down), 4'b0011);

        // Extended prefix suppresses event, then flag is cleared
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("relA2_down", int'(key_down), 4'b0010);
        ev0 = ev_cnt;
        send_byte(8'hE0);
        send_byte(8'h1C);
        check("ext_ev",   ev_cnt - ev0, 0);
        check("ext_down", int'(key_down), 4'b0010);
        send_byte(8'h1C);
        check("postext_ev",   ev_cnt - ev0, 1);
        check("postext_idx",  ev_idx, 0);
        check("postext_make", ev_make, 1);

        // Unmapped byte
        ev0 = ev_cnt;
        send_byte(8'h15);
        check("unmapped_ev", ev_cnt - ev0, 0);

        // Stalled frame -> watchdog
        ev0 = ev_cnt; er0 = err_cnt;
        send_frame(8'h2B, 1'b0, 5, 1'b0);
        check("stall_early_err", err_cnt - er0, 0);
        wait_cyc(TMO + 50);
        check("stall_err", err_cnt - er0, 1);
        check("stall_ev",  ev_cnt - ev0, 0);
        send_byte(8'h2B);
        check("pressF_ev",   ev_cnt - ev0, 1);
        check("pressF_idx",  ev_idx, 3);
        check("pressF_make", ev_make, 1);
        check("pressF_down", int'(key_down), 4'b1011);

        // Break for a key not held
        ev0 = ev_cnt;
        send_byte(8'hF0);
        send_byte(8'h23);
        check("brk_notdown_ev", ev_cnt - ev0, 0);
        check("brk_notdown_down", int'(key_down), 4'b1011);

        // Glitched clock during release of S
        ev0 = ev_cnt; er0 = err_cnt;
        send_byte(8'hF0);
        send_frame(8'h1B, 1'b0, 11, 1'b1);
        check("glitch_ev",   ev_cnt - ev0, 1);
        check("glitch_idx",  ev_idx, 1);
        check("glitch_make", ev_make, 0);
        check("glitch_down", int'(key_down), 4'b1001);
        check("glitch_err",  err_cnt - er0, 0);

        // Reset in mid-frame
        send_frame(8'h23, 1'b0, 5, 1'b0);
        reset = 1'b1;
        wait_cyc(1);
        check("midrst_valid", int'(key_valid), 0);
        check("midrst_ferr",  int'(frame_error), 0);
        check("midrst_down",  int'(key_down), 0);
        check("midrst_index", int'(key_index), 0);
        check("midrst_make",  int'(key_make), 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(20);
        ev0 = ev_cnt; er0 = err_cnt;
        send_byte(8'h1C);
        check("postrst_ev",   ev_cnt - ev0, 1);
        check("postrst_idx",  ev_idx, 0);
        check("postrst_down", int'(key_down), 4'b0001);
        check("postrst_err",  err_cnt - er0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
